// File: rtl/ram_3port_ctrl_pkg.sv
// Shared definitions for the MMU-table RAM controller.
//   state_t         : controller FSM states (zero-fill, then normal operation)
//   DEF_ADDR_WIDTH  : default table address width used by all MMU tables
//   DEF_DATA_WIDTH  : default table word width
//   DEF_NUM_RD      : default number of read clients
package ram_3port_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_NUM_RD     = 4;

endpackage

// File: rtl/ram_3port_ctrl_if.sv
// Client bus of the MMU-table RAM controller.
//   wr_req/wr_addr/wr_data -> wr_gnt            : 2 write clients, valid/ready
//   rd_req/rd_addr         -> rd_gnt            : NUM_RD read clients, valid/ready
//   rd_rsp_valid/rd_rsp_data                    : read responses, 1 cycle after grant
// Client i occupies slice [i*W +: W] of every packed vector.
// Modports: master = client side, slave = controller side.
interface ram_3port_ctrl_if
  import ram_3port_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_RD     = DEF_NUM_RD
);

  logic [1:0]                   wr_req;
  logic [2*ADDR_WIDTH-1:0]      wr_addr;
  logic [2*DATA_WIDTH-1:0]      wr_data;
  logic [1:0]                   wr_gnt;

  logic [NUM_RD-1:0]            rd_req;
  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD-1:0]            rd_gnt;
  logic [NUM_RD-1:0]            rd_rsp_valid;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_rsp_data;

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr,
    input  wr_gnt, rd_gnt, rd_rsp_valid, rd_rsp_data
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
    output wr_gnt, rd_gnt, rd_rsp_valid, rd_rsp_data
  );

endinterface

// File: rtl/ram_3port_ctrl_ram.sv
// ram_3port: 1 write port, 2 registered read ports.
//   i_clk              : clock, rising edge
//   i_we/i_waddr/i_wdata : write port, memory updated at the edge
//   i_raddr1/i_raddr2  : read addresses
//   o_rdata1/o_rdata2  : read data, registered (1 cycle latency)
// A read whose address equals i_waddr returns i_wdata regardless of i_we,
// which gives write-first behaviour for a same-cycle write and read.
module ram_3port
  import ram_3port_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr1,
  input  logic [ADDR_WIDTH-1:0] i_raddr2,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic [DATA_WIDTH-1:0] o_rdata2
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata1;
  logic [DATA_WIDTH-1:0] r_rdata2;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata1 <= (i_raddr1 == i_waddr) ? i_wdata : r_mem[i_raddr1];
    r_rdata2 <= (i_raddr2 == i_waddr) ? i_wdata : r_mem[i_raddr2];
  end

  assign o_rdata1 = r_rdata1;
  assign o_rdata2 = r_rdata2;

endmodule

// File: rtl/ram_3port_ctrl.sv
// ram_3port_ctrl: controller/arbiter around one ram_3port (MMU tables).
//   i_clk       : clock, rising edge
//   i_rst_n     : asynchronous active-low reset
//   o_init_done : 1 once the post-reset fill with INIT_VALUE has completed
//   bus         : client bus (slave side), 2 write and NUM_RD read clients
// After reset every entry is written with INIT_VALUE, one per cycle; no
// client is granted until that is done. Then the single write port is
// shared round-robin between the 2 writers and the 2 read ports between
// the NUM_RD readers. Read responses come back one cycle after the grant.
module ram_3port_ctrl
  import ram_3port_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    NUM_RD     = DEF_NUM_RD,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_init_done,
  ram_3port_ctrl_if.slave bus
);

  localparam int AW    = ADDR_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int RRW   = $clog2(NUM_RD);
  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

  typedef struct packed {
    logic           v1;
    logic           v2;
    logic [RRW-1:0] i1;
    logic [RRW-1:0] i2;
    logic [RRW-1:0] nxt;
  } rd_pick_t;

  // Scan from rr upward (mod NUM_RD); the first two requesters win ports
  // 1 and 2, and the pointer moves just past the last one picked.
  function automatic rd_pick_t rr_pick2(input logic [NUM_RD-1:0] req,
                                        input logic [RRW-1:0]    rr);
    rd_pick_t       p;
    int             c;
    logic [RRW-1:0] ci;
    p     = '0;
    p.nxt = rr;
    for (int k = 0; k < NUM_RD; k++) begin
      c  = (int'(rr) + k) % NUM_RD;
      ci = RRW'(c);
      if (req[ci] && !p.v2) begin
        if (!p.v1) begin
          p.v1 = 1'b1;
          p.i1 = ci;
        end else begin
          p.v2 = 1'b1;
          p.i2 = ci;
        end
        p.nxt = RRW'((c + 1) % NUM_RD);
      end
    end
    return p;
  endfunction

  state_t          r_state;
  logic [AW:0]     r_init_cnt;
  logic            r_init_done;
  logic            r_wr_rr;
  logic [RRW-1:0]  r_rd_rr;
  logic [AW-1:0]   r_last_waddr;
  logic [DW-1:0]   r_last_wdata;
  logic [1:0]      r_rsp_vld_p1;
  logic [RRW-1:0]  r_rsp_idx_p1 [2];

  logic            w_run;
  logic [1:0]      w_wr_gnt;
  rd_pick_t        w_pick;
  logic [NUM_RD-1:0] w_rd_gnt;
  logic            w_we;
  logic [AW-1:0]   w_waddr;
  logic [DW-1:0]   w_wdata;
  logic [AW-1:0]   w_raddr1;
  logic [AW-1:0]   w_raddr2;
  logic [DW-1:0]   w_rdata1;
  logic [DW-1:0]   w_rdata2;

  // Grants are only ever given in RUN, so an asynchronous reset (which
  // forces INIT) removes every grant at once.
  assign w_run = (r_state == ST_RUN);

  always_comb begin
    w_wr_gnt = 2'b00;
    if (w_run) begin
      if (bus.wr_req == 2'b11) w_wr_gnt = r_wr_rr ? 2'b10 : 2'b01;
      else                     w_wr_gnt = bus.wr_req;
    end
  end

  // An idle write port replays the last performed write so that the RAM's
  // address-match bypass returns what memory actually holds.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_last_waddr;
    w_wdata = r_last_wdata;
    if (!w_run) begin
      w_we    = 1'b1;
      w_waddr = r_init_cnt[AW-1:0];
      w_wdata = INIT_VALUE;
    end else if (w_wr_gnt[1]) begin
      w_we    = 1'b1;
      w_waddr = bus.wr_addr[AW +: AW];
      w_wdata = bus.wr_data[DW +: DW];
    end else if (w_wr_gnt[0]) begin
      w_we    = 1'b1;
      w_waddr = bus.wr_addr[0 +: AW];
      w_wdata = bus.wr_data[0 +: DW];
    end
  end

  always_comb begin
    w_pick = '0;
    if (w_run) w_pick = rr_pick2(bus.rd_req, r_rd_rr);
    w_rd_gnt = '0;
    if (w_pick.v1) w_rd_gnt[w_pick.i1] = 1'b1;
    if (w_pick.v2) w_rd_gnt[w_pick.i2] = 1'b1;
    w_raddr1 = bus.rd_addr[w_pick.i1*AW +: AW];
    w_raddr2 = bus.rd_addr[w_pick.i2*AW +: AW];
  end

  assign bus.wr_gnt = w_wr_gnt;
  assign bus.rd_gnt = w_rd_gnt;

  // ---- stage p0 -> p1: FSM, arbitration pointers, response tags ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= ST_INIT;
      r_init_cnt      <= '0;
      r_init_done     <= 1'b0;
      r_wr_rr         <= 1'b0;
      r_rd_rr         <= '0;
      r_rsp_vld_p1    <= 2'b00;
      r_rsp_idx_p1[0] <= '0;
      r_rsp_idx_p1[1] <= '0;
    end else begin
      if (r_state == ST_INIT) begin
        r_init_cnt <= r_init_cnt + 1'b1;
        if (r_init_cnt == LAST_IDX) begin
          r_state     <= ST_RUN;
          r_init_done <= 1'b1;
        end
      end else begin
        if (bus.wr_req == 2'b11) r_wr_rr <= ~r_wr_rr;
        if (w_pick.v1)           r_rd_rr <= w_pick.nxt;
      end
      r_rsp_vld_p1    <= {w_pick.v2, w_pick.v1};
      r_rsp_idx_p1[0] <= w_pick.i1;
      r_rsp_idx_p1[1] <= w_pick.i2;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_we) begin
      r_last_waddr <= w_waddr;
      r_last_wdata <= w_wdata;
    end
  end

  ram_3port #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) u_ram (
    .i_clk    (i_clk),
    .i_we     (w_we),
    .i_waddr  (w_waddr),
    .i_wdata  (w_wdata),
    .i_raddr1 (w_raddr1),
    .i_raddr2 (w_raddr2),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2)
  );

  // ---- stage p1: route RAM port data to the tagged client slots ----
  always_comb begin
    bus.rd_rsp_valid = '0;
    bus.rd_rsp_data  = '0;
    if (r_rsp_vld_p1[0]) begin
      bus.rd_rsp_valid[r_rsp_idx_p1[0]]            = 1'b1;
      bus.rd_rsp_data[r_rsp_idx_p1[0]*DW +: DW] = w_rdata1;
    end
    if (r_rsp_vld_p1[1]) begin
      bus.rd_rsp_valid[r_rsp_idx_p1[1]]            = 1'b1;
      bus.rd_rsp_data[r_rsp_idx_p1[1]*DW +: DW] = w_rdata2;
    end
  end

  assign o_init_done = r_init_done;

endmodule

// File: tb/tb_ram_3port_ctrl.sv
// Bench for ram_3port_ctrl: directed stimulus with literal expectations plus
// a cycle-level reference model checked on every falling clock edge.
module tb_ram_3port_ctrl;

  localparam int AW    = 6;
  localparam int DW    = 64;
  localparam int NR    = 4;
  localparam int DEPTH = 64;

  logic clk;
  logic rst_n;
  logic init_done;

  int n_checks;
  int n_errs;

  ram_3port_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR)) bus ();

  ram_3port_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_RD     (NR),
    .INIT_VALUE (64'h0)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .o_init_done (init_done),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_addr[c*AW +: AW] = a;
    bus.wr_data[c*DW +: DW] = d;
  endtask

  task automatic set_rd(input int c, input logic [AW-1:0] a);
    bus.rd_addr[c*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] slot(input int c);
    return bus.rd_rsp_data[c*DW +: DW];
  endfunction

  // Counts edges after reset release until init_done; notes any grant seen.
  task automatic wait_init(output int n, output logic gnt_seen);
    n = 0;
    gnt_seen = 1'b0;
    while (init_done !== 1'b1 && n < 200) begin
      #2;
      if (bus.wr_gnt !== 2'b00 || bus.rd_gnt !== 4'b0000) gnt_seen = 1'b1;
      tick();
      n++;
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0]    m_mem [DEPTH];
  int               m_cnt;
  int               m_rpref;
  logic             m_wpref;
  logic [NR-1:0]    m_rsp_v;
  logic [NR*DW-1:0] m_rsp_d;

  initial begin : model
    logic          run;
    logic [1:0]    ewg;
    logic [NR-1:0] erg;
    int            ng;
    int            last;
    int            c;
    int            wc;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        chk("rst_init_done", init_done, 0);
        chk("rst_wr_gnt", bus.wr_gnt, 0);
        chk("rst_rd_gnt", bus.rd_gnt, 0);
        chk("rst_rsp_valid", bus.rd_rsp_valid, 0);
        chk("rst_rsp_data", bus.rd_rsp_data, 0);
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_cnt   = 0;
        m_rpref = 0;
        m_wpref = 1'b0;
        m_rsp_v = '0;
        m_rsp_d = '0;
      end else begin
        run  = (m_cnt >= DEPTH);
        ewg  = 2'b00;
        erg  = '0;
        ng   = 0;
        last = 0;
        if (run) begin
          if (bus.wr_req == 2'b11) ewg = m_wpref ? 2'b10 : 2'b01;
          else                     ewg = bus.wr_req;
          for (int k = 0; k < NR; k++) begin
            c = (m_rpref + k) % NR;
            if (bus.rd_req[c] && ng < 2) begin
              erg[c] = 1'b1;
              ng++;
              last = c;
            end
          end
        end
        chk("m_init_done", init_done, run);
        chk("m_wr_gnt", bus.wr_gnt, ewg);
        chk("m_rd_gnt", bus.rd_gnt, erg);
        chk("m_rsp_valid", bus.rd_rsp_valid, m_rsp_v);
        chk("m_rsp_data", bus.rd_rsp_data, m_rsp_d);
        // effect of the coming edge: write first, then the reads see it
        if (ewg != 2'b00) begin
          wc = ewg[1] ? 1 : 0;
          m_mem[bus.wr_addr[wc*AW +: AW]] = bus.wr_data[wc*DW +: DW];
        end
        m_rsp_v = erg;
        m_rsp_d = '0;
        for (int i = 0; i < NR; i++)
          if (erg[i]) m_rsp_d[i*DW +: DW] = m_mem[bus.rd_addr[i*AW +: AW]];
        if (run && bus.wr_req == 2'b11) m_wpref = ~m_wpref;
        if (ng > 0) m_rpref = (last + 1) % NR;
        if (m_cnt < DEPTH) m_cnt++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  localparam logic [DW-1:0] PAT7 = 64'h0123_4567_89AB_CDEF;
  localparam logic [DW-1:0] DA   = 64'h1111_AAAA_1111_AAAA;
  localparam logic [DW-1:0] DB   = 64'h2222_BBBB_2222_BBBB;
  localparam logic [DW-1:0] DEAD = 64'h0000_0000_0000_DEAD;

  initial begin : stim
    int         n;
    logic       gs;
    logic [1:0] g [4];
    n_checks    = 0;
    n_errs      = 0;
    rst_n       = 1'b1;
    bus.wr_req  = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_req  = '0;
    bus.rd_addr = '0;
    #2 rst_n = 1'b0;
    repeat (3) tick();

    // requests pending across reset release and the whole fill
    set_rd(0, 0); set_rd(1, 1); set_rd(2, 2); set_rd(3, 7);
    bus.rd_req = 4'b1111;
    set_wr(0, 7, PAT7);
    bus.wr_req = 2'b01;
    rst_n = 1'b1;
    wait_init(n, gs);
    chk("init_latency", n, 64);
    chk("no_gnt_in_init", gs, 0);
    #2;
    chk("first_run_rd_gnt", bus.rd_gnt, 4'b0011);
    chk("first_run_wr_gnt", bus.wr_gnt, 2'b01);
    tick();
    bus.wr_req = 2'b00;
    #2;
    chk("rr_rd_gnt_2", bus.rd_gnt, 4'b1100);
    chk("rr_rsp_valid_1", bus.rd_rsp_valid, 4'b0011);
    chk("rr_slot1_zero", slot(1), 0);
    tick();
    #2;
    chk("rr_rd_gnt_3", bus.rd_gnt, 4'b0011);
    chk("rr_rsp_valid_2", bus.rd_rsp_valid, 4'b1100);
    chk("rr_slot3_addr7", slot(3), PAT7);
    bus.rd_req = 4'b0000;
    tick();

    // read every address, two per cycle
    for (int a = 0; a < DEPTH; a += 2) begin
      set_rd(0, AW'(a));
      set_rd(1, AW'(a + 1));
      bus.rd_req = 4'b0011;
      tick();
    end
    bus.rd_req = 4'b0000;
    #2;
    chk("sweep_addr63_zero", slot(1), 0);
    tick();

    // contending writers to one address
    set_wr(0, 10, DA);
    set_wr(1, 10, DB);
    bus.wr_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #2;
      g[i] = bus.wr_gnt;
      tick();
    end
    bus.wr_req = 2'b00;
    chk("wr_rr_0", g[0], 2'b01);
    chk("wr_rr_1", g[1], 2'b10);
    chk("wr_rr_2", g[2], 2'b01);
    chk("wr_rr_3", g[3], 2'b10);
    set_rd(2, 10);
    bus.rd_req = 4'b0100;
    tick();
    bus.rd_req = 4'b0000;
    #2;
    chk("shared_addr_rsp_valid", bus.rd_rsp_valid, 4'b0100);
    chk("shared_addr_data", slot(2), DB);

    // two reads of the same address in one cycle
    set_rd(0, 10);
    set_rd(3, 10);
    bus.rd_req = 4'b1001;
    tick();
    bus.rd_req = 4'b0000;
    #2;
    chk("dup_rsp_valid", bus.rd_rsp_valid, 4'b1001);
    chk("dup_slot0", slot(0), DB);
    chk("dup_slot3", slot(3), DB);

    // same-cycle write and read of one address, then idle-port reads
    set_wr(0, 5, DEAD);
    bus.wr_req = 2'b01;
    set_rd(1, 5);
    bus.rd_req = 4'b0010;
    tick();
    bus.wr_req = 2'b00;
    bus.rd_req = 4'b0000;
    #2;
    chk("write_first_data", slot(1), DEAD);
    set_rd(0, 5);
    set_rd(1, 63);
    bus.rd_req = 4'b0011;
    tick();
    bus.rd_req = 4'b0000;
    #2;
    chk("idle_addr5", slot(0), DEAD);
    chk("idle_addr63", slot(1), 0);

    // reset in the middle of traffic
    set_wr(0, 20, DA);
    bus.wr_req = 2'b01;
    set_rd(2, 5);
    bus.rd_req = 4'b0100;
    tick();
    #2;
    chk("pre_rst_wr_gnt", bus.wr_gnt, 2'b01);
    chk("pre_rst_rsp_valid", bus.rd_rsp_valid, 4'b0100);
    rst_n = 1'b0;
    #1;
    chk("rst_drop_wr_gnt", bus.wr_gnt, 0);
    chk("rst_drop_rd_gnt", bus.rd_gnt, 0);
    chk("rst_drop_rsp_valid", bus.rd_rsp_valid, 0);
    chk("rst_drop_init_done", init_done, 0);
    bus.wr_req = 2'b00;
    bus.rd_req = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
    wait_init(n, gs);
    chk("reinit_latency", n, 64);
    set_rd(0, 5);
    set_rd(1, 10);
    bus.rd_req = 4'b0011;
    tick();
    set_rd(0, 7);
    set_rd(1, 20);
    #2;
    chk("reinit_addr5", slot(0), 0);
    chk("reinit_addr10", slot(1), 0);
    tick();
    bus.rd_req = 4'b0000;
    #2;
    chk("reinit_addr7", slot(0), 0);
    chk("reinit_addr20", slot(1), 0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errs);
    $fatal(1);
  end

endmodule
